load_store_unit: RTL and testbench

Multi-cycle initiator that sits between the core's execute/memory stage and the data port of the unified word-wide memory. It accepts one load/store request at a time, using RISC-V funct3 encoding. It drives MemRead/MemWrite/data_addr/data_in toward memory and consumes data_out. It performs byte-lane extraction with sign/zero extension for loads, read-modify-write for sb/sh, and alignment/range checking.

---
 rtl/load_store_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle initiator between the core's execute/memory stage and the
//   data port of a unified word-wide memory. It takes one load/store at a time,
//   using RISC-V funct3 encoding. Loads get byte-lane extraction with sign or
//   zero extension. sb/sh are done as read-modify-write. Misaligned, illegal or
//   out-of-range requests are answered with an error and never touch memory.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while IDLE
//   req_write            1 = store, 0 = load
//   req_funct3           000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr, req_wdata  byte address and store data
//   rsp_valid            one-cycle response pulse (no backpressure)
//   rsp_rdata, rsp_err   load result / error flag, held until the next response
//   MemRead, MemWrite    memory strobes; memory writes on the same rising edge
//   data_addr, data_in   word-aligned address and full write word
//   data_out             combinational memory read data (only used in READ)
//   dbg_state            current FSM state (IDLE=0, READ=1, WRITE=2, RESP=3)
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE and never during reset. Requests presented
// outside IDLE are ignored, not queued. The requester must hold its fields
// until the transfer edge. Responses cannot be stalled: rsp_valid is high for
// exactly one cycle per accepted request, and responses come back in order.

module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] data_addr,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;      // addr[1:0] of the latched request
  logic [15:0] wdata_q, wdata_d;    // only the low half is needed after accept
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_in_q, data_in_d;

  // Request checks, evaluated on the live request fields at accept.
  logic f3_illegal;
  logic misaligned;
  logic out_of_range;
  logic req_err;

  always_comb begin
    if (req_write) begin
      f3_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      f3_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    end
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr[31:2] >= WORD_LIMIT);
    req_err = f3_illegal || misaligned || out_of_range;
  end

  // Load lane extraction from the word returned in READ.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  always_comb begin
    sel_byte = data_out[7:0];
    case (lane_q)
      2'd0: sel_byte = data_out[7:0];
      2'd1: sel_byte = data_out[15:8];
      2'd2: sel_byte = data_out[23:16];
      2'd3: sel_byte = data_out[31:24];
      default: sel_byte = data_out[7:0];
    endcase
    sel_half = lane_q[1] ? data_out[31:16] : data_out[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = data_out;
    endcase
  end

  // Read-modify-write merge for sb/sh: replace only the addressed lane.
  logic [31:0] merged_word;

  always_comb begin
    merged_word = data_out;
    if (funct3_q[0]) begin
      if (lane_q[1]) merged_word[31:16] = wdata_q;
      else           merged_word[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0: merged_word[7:0]   = wdata_q[7:0];
        2'd1: merged_word[15:8]  = wdata_q[7:0];
        2'd2: merged_word[23:16] = wdata_q[7:0];
        2'd3: merged_word[31:24] = wdata_q[7:0];
        default: merged_word = data_out;
      endcase
    end
  end

  // Next-state logic. Memory strobes and the response pulse are registered,
  // so each is computed one state ahead of the cycle in which it appears.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    data_addr_d = data_addr_q;
    data_in_d   = data_in_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata[15:0];
          if (req_err) begin
            // Rejected requests skip memory entirely; data_addr keeps the
            // address of the last real access.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else if (req_write && (req_funct3 == 3'b010)) begin
            state_d     = S_WRITE;
            mem_write_d = 1'b1;
            data_addr_d = {req_addr[31:2], 2'b00};
            data_in_d   = req_wdata;
          end else begin
            // Loads and sub-word stores both start by reading the word.
            state_d     = S_READ;
            mem_read_d  = 1'b1;
            data_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      S_READ: begin
        if (write_q) begin
          state_d     = S_WRITE;
          mem_write_d = 1'b1;
          data_in_d   = merged_word;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
        end
      end
      S_WRITE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      data_addr_q <= 32'd0;
      data_in_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      data_addr_q <= data_addr_d;
      data_in_q   <= data_in_d;
    end
  end

  // Strobes are gated by reset so a reset landing in WRITE blocks that
  // edge's memory write instead of waiting for the registers to clear.
  assign MemRead   = mem_read_q && !reset;
  assign MemWrite  = mem_write_q && !reset;
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign data_addr = data_addr_q;
  assign data_in   = data_in_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural memory, reference model,
// scoreboard of expected responses, one task per scenario.

module tb_load_store_unit;

  // Scoreboard entry: {err, rdata[31:0], latency[3:0], reads[1:0], writes[1:0]}
  localparam int W = 41;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [1:0]  dbg_state;

  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_dat = 32'd0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [W-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rd_snap = 0;
  int wr_snap = 0;
  int acc_cyc = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .data_addr(data_addr),
    .data_in(data_in), .data_out(data_out), .dbg_state(dbg_state)
  );

  // ---------------- memory ----------------
  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_dat;
    else if (MemWrite && (data_addr[31:10] == 22'd0)) mem[data_addr[9:2]] <= data_in;
  end

  assign data_out = (MemRead && (data_addr[31:10] == 22'd0)) ? mem[data_addr[9:2]] : 32'h0BAD_0BAD;

  // ---------------- reference model ----------------
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [W-1:0] e);
    logic err;
    logic [31:0] r, old, nw;
    logic [7:0] b;
    logic [15:0] h;
    int lat, nr, nwr;
    if (w) err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else   err = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) err = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'd0) err = 1'b1;
    if (a[31:2] >= 256) err = 1'b1;
    r = 32'd0; lat = 1; nr = 0; nwr = 0;
    if (!err) begin
      old = ref_mem[a[9:2]];
      b = old[8*a[1:0] +: 8];
      h = a[1] ? old[31:16] : old[15:0];
      if (!w) begin
        lat = 2; nr = 1;
        case (f3)
          3'd0: r = {{24{b[7]}}, b};
          3'd1: r = {{16{h[15]}}, h};
          3'd4: r = {24'd0, b};
          3'd5: r = {16'd0, h};
          default: r = old;
        endcase
      end else if (f3 == 3'd2) begin
        lat = 2; nwr = 1;
        ref_mem[a[9:2]] = wd;
      end else begin
        lat = 3; nr = 1; nwr = 1;
        nw = old;
        if (f3 == 3'd0) nw[8*a[1:0] +: 8] = wd[7:0];
        else            nw[16*a[1] +: 16] = wd[15:0];
        ref_mem[a[9:2]] = nw;
      end
    end
    e = {err, r, 4'(lat), 2'(nr), 2'(nwr)};
  endtask

  // One clock cycle: sample at the falling edge (scoreboard push/pop), then
  // return 1 time unit after the rising edge so callers can drive inputs.
  task automatic cycle();
    logic [W-1:0] e, got;
    @(negedge clk);
    if (MemRead)  rd_cnt++;
    if (MemWrite) wr_cnt++;
    checks++;
    if (MemRead && MemWrite) begin
      errors++;
      $display("FAIL strobes: MemRead=1 MemWrite=1 together, required at most one at cycle %0d", cyc);
    end
    if (req_valid && req_ready) begin
      model(req_write, req_funct3, req_addr, req_wdata, e);
      exp_q.push_back(e);
      acc_cyc = cyc + 1;
      rd_snap = rd_cnt;
      wr_snap = wr_cnt;
      acc_cnt++;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding request at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        got = {rsp_err, rsp_rdata, 4'(cyc - acc_cyc + 1), 2'(rd_cnt - rd_snap), 2'(wr_cnt - wr_snap)};
        if (got !== e) begin
          errors++;
          $display("FAIL rsp: got err=%0b rdata=%08h lat=%0d rd=%0d wr=%0d, expected err=%0b rdata=%08h lat=%0d rd=%0d wr=%0d",
                   got[40], got[39:8], got[7:4], got[3:2], got[1:0],
                   e[40], e[39:8], e[7:4], e[3:2], e[1:0]);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload_word(input int idx, input logic [31:0] v);
    pl_we = 1'b1; pl_idx = 8'(idx); pl_dat = v;
    ref_mem[idx] = v;
    cycle();
    pl_we = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int start, n;
    start = acc_cnt; n = 0;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (acc_cnt == start && n < 20) begin
      cycle();
      n++;
    end
    req_valid = 1'b0;
    if (acc_cnt == start) begin
      checks++; errors++;
      $display("FAIL accept_timeout: request addr=%08h not accepted, required accept within 20 cycles", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 4)        preload_word(i, 32'h80FF_7F01);
      else if (i == 255) preload_word(i, 32'hA55A_C33C);
      else               preload_word(i, 32'h1000_0000 | 32'(i));
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_reset: req_ready=%0b, required 0", req_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, MemRead, MemWrite, dbg_state} !== 7'b100_0000) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%0b rsp_valid=%0b err=%0b rd=%0b wr=%0b state=%0d, required 1 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, MemRead, MemWrite, dbg_state);
    end
    checks++;
    if ({rsp_rdata, data_addr, data_in} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: rdata=%08h data_addr=%08h data_in=%08h, required all 0", rsp_rdata, data_addr, data_in);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [6] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5, 3'd2};
    logic [31:0] adrs [6] = '{32'h12, 32'h12, 32'h11, 32'h12, 32'h12, 32'h10};
    logic [31:0] exps [6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_007F,
                             32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'd0);
      drain();
      checks++;
      if (rsp_rdata !== exps[i] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: f3=%0d addr=%08h got rdata=%08h err=%0b, required %08h err=0",
                 i, f3s[i], adrs[i], rsp_rdata, rsp_err, exps[i]);
      end
    end
  endtask

  task automatic test_stores();
    issue(1'b1, 3'd0, 32'h11, 32'hDEAD_BEAB);
    drain();
    checks++;
    if (mem[4] !== 32'h80FF_AB01 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL sb: mem[4]=%08h rdata=%08h, required 80ffab01 and 0", mem[4], rsp_rdata);
    end
    preload_word(4, 32'h80FF_7F01);
    issue(1'b1, 3'd1, 32'h12, 32'h0000_1234);
    drain();
    checks++;
    if (mem[4] !== 32'h1234_7F01) begin
      errors++; $display("FAIL sh: mem[4]=%08h, required 12347f01", mem[4]);
    end
    issue(1'b1, 3'd2, 32'h14, 32'hCAFE_F00D);
    drain();
    checks++;
    if (mem[5] !== 32'hCAFE_F00D || data_addr !== 32'h14) begin
      errors++; $display("FAIL sw: mem[5]=%08h data_addr=%08h, required cafef00d and 00000014", mem[5], data_addr);
    end
  endtask

  task automatic test_errors();
    logic        ws   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [6] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6};
    logic [31:0] adrs [6] = '{32'h13, 32'h11, 32'h10, 32'h400, 32'h10, 32'h10};
    logic [31:0] m4, m5;
    m4 = mem[4]; m5 = mem[5];
    for (int i = 0; i < 6; i++) begin
      issue(ws[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
      drain();
      checks++;
      if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
        errors++;
        $display("FAIL err_%0d: w=%0b f3=%0d addr=%08h got err=%0b rdata=%08h, required err=1 rdata=0",
                 i, ws[i], f3s[i], adrs[i], rsp_err, rsp_rdata);
      end
    end
    checks++;
    if (mem[4] !== m4 || mem[5] !== m5 || data_addr !== 32'h14) begin
      errors++;
      $display("FAIL err_side_effects: mem4=%08h mem5=%08h data_addr=%08h, required %08h %08h 00000014",
               mem[4], mem[5], data_addr, m4, m5);
    end
    // Highest legal word.
    issue(1'b0, 3'd2, 32'h3FC, 32'd0);
    drain();
    checks++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'hA55A_C33C) begin
      errors++; $display("FAIL lw_last_word: err=%0b rdata=%08h, required 0 a55ac33c", rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset_in_write();
    logic [31:0] saved;
    saved = ref_mem[4];
    issue(1'b1, 3'd0, 32'h10, 32'h0000_0077);
    cycle();
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++; $display("FAIL rst_write_state: state=%0d, required 2 (WRITE)", dbg_state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_gate: MemWrite=%0b req_ready=%0b, required 0 0", MemWrite, req_ready);
    end
    cycle();
    reset = 1'b0;
    exp_q.delete();
    ref_mem[4] = saved;
    #1;
    checks++;
    if (mem[4] !== saved) begin
      errors++; $display("FAIL rst_no_write: mem[4]=%08h, required %08h", mem[4], saved);
    end
    checks++;
    if ({dbg_state, req_ready, rsp_valid, rsp_err, MemRead, MemWrite} !== 7'b00_10000 ||
        {rsp_rdata, data_addr, data_in} !== 96'd0) begin
      errors++;
      $display("FAIL rst_outputs: state=%0d ready=%0b rsp_valid=%0b err=%0b rd=%0b wr=%0b rdata=%08h addr=%08h din=%08h, required IDLE ready=1 rest 0",
               dbg_state, req_ready, rsp_valid, rsp_err, MemRead, MemWrite, rsp_rdata, data_addr, data_in);
    end
  endtask

  task automatic test_back_to_back();
    int acc0, rsp0, gap;
    acc0 = acc_cnt; rsp0 = rsp_cnt;
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_write  = k[0];
      req_funct3 = 3'd2;
      req_addr   = 32'(32 + 4 * (k % 4));
      req_wdata  = $urandom;
      gap = 0;
      while (acc_cnt == acc0 + k && gap < 20) begin
        cycle();
        if (acc_cnt == acc0 + k) gap++;
      end
      if (k > 0) begin
        checks++;
        if (gap !== 2) begin
          errors++; $display("FAIL b2b_gap_%0d: %0d idle-less cycles between accepts, required 2", k, gap);
        end
      end
    end
    req_valid = 1'b0;
    drain();
    checks++;
    if (acc_cnt - acc0 !== 8 || rsp_cnt - rsp0 !== 8) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d responses=%0d, required 8 and 8", acc_cnt - acc0, rsp_cnt - rsp0);
    end
  endtask

  task automatic test_random();
    int sel, word, mism;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      word = (sel == 0) ? 256 : (sel == 1) ? 255 : $urandom_range(8, 15);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'(word * 4 + $urandom_range(0, 3)), $urandom);
      drain();
    end
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL mem_final: %0d words differ from model, required 0", mism);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_in_write();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
